// File: rtl/fht_bitrev_reorder.sv
// fht_bitrev_reorder
//
// Bit-reverse reorder engine between an FHT result RAM and the next
// transform's input RAM. Every clock, one row (N_BANK words) is read from
// the source RAM and written to the destination RAM at the natural-order
// address. In reorder mode the source row is taken at the bit-reversed
// address. In copy mode it is taken at the same address.
//
// Ports:
//   iCLK      clock
//   iRESET    synchronous active-high reset; aborts a run immediately
//   iSTART    start pulse, only looked at while idle
//   iMODE     0 = bit-reverse reorder, 1 = linear copy (latched at start)
//   oADDR_RD  source read address, shared by all banks
//   iDATA_RD  source read data, bank b in [b*D_BIT +: D_BIT]
//   oADDR_WR  destination write address, shared by all banks
//   oDATA_WR  destination write data, packed like iDATA_RD
//   oWE       per-bank write enable (all bits equal)
//   oBUSY     high while a run is in progress
//   oRDY      one-cycle done pulse
//
// Optional feature: define FHT_REORDER_SCALE_EN to scale every word.
// Each word is shifted arithmetically right by SHIFT with round-half-up,
// then saturated to the signed D_BIT range. This adds one register stage,
// so the write latency and the oRDY latency each grow by one clock.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for iSTART
// S_READ  | issuing one source row address per clock
// S_DRAIN | letting the read/write pipeline empty
// S_DONE  | oRDY high for this cycle, back to idle next

module fht_bitrev_reorder #(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 8,
  parameter int N_BANK = 4,
  parameter int RD_LAT = 1,
  parameter int SHIFT  = 0
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      iSTART,
  input  logic                      iMODE,
  output logic [A_BIT-1:0]          oADDR_RD,
  input  logic [N_BANK*D_BIT-1:0]   iDATA_RD,
  output logic [A_BIT-1:0]          oADDR_WR,
  output logic [N_BANK*D_BIT-1:0]   oDATA_WR,
  output logic [N_BANK-1:0]         oWE,
  output logic                      oBUSY,
  output logic                      oRDY
);

`ifdef FHT_REORDER_SCALE_EN
  localparam int P_LAT = RD_LAT + 1;
`else
  localparam int P_LAT = RD_LAT;
`endif

  localparam logic [A_BIT-1:0] CNT_MAX    = '1;
  localparam logic [1:0]       DRAIN_LOAD = 2'(P_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [A_BIT-1:0] cnt;
  logic [A_BIT-1:0] cnt_nxt;
  logic             mode_q;
  logic             rd_v;
  logic [1:0]       drain_cnt;

  // Write-side pipeline: the valid flag and the row index are delayed to
  // match the source RAM latency (plus the scaling stage when it is present).
  logic [P_LAT-1:0] v_pipe;
  logic [A_BIT-1:0] a_pipe [P_LAT];

  function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] a);
    logic [A_BIT-1:0] r;
    for (int i = 0; i < A_BIT; i++) r[i] = a[A_BIT-1-i];
    return r;
  endfunction

  assign cnt_nxt = cnt + A_BIT'(1);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      rd_v      <= 1'b0;
      drain_cnt <= '0;
      oADDR_RD  <= '0;
      oBUSY     <= 1'b0;
      oRDY      <= 1'b0;
    end else begin
      oRDY <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iSTART) begin
            state    <= S_READ;
            mode_q   <= iMODE;
            cnt      <= '0;
            rd_v     <= 1'b1;
            // Row 0 maps to address 0 in both modes.
            oADDR_RD <= '0;
            oBUSY    <= 1'b1;
          end
        end
        S_READ: begin
          // Leave on the last row without advancing cnt, so the wrap never
          // produces an extra read.
          if (cnt == CNT_MAX) begin
            state     <= S_DRAIN;
            rd_v      <= 1'b0;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            cnt      <= cnt_nxt;
            oADDR_RD <= mode_q ? cnt_nxt : bitrev(cnt_nxt);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state <= S_DONE;
            oRDY  <= 1'b1;
            oBUSY <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      v_pipe <= '0;
      for (int i = 0; i < P_LAT; i++) a_pipe[i] <= '0;
    end else begin
      v_pipe[0] <= rd_v;
      a_pipe[0] <= cnt;
      for (int i = 1; i < P_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        a_pipe[i] <= a_pipe[i-1];
      end
    end
  end

  // The write enable is gated by iRESET so that an abort also suppresses
  // the write that is already in flight during the reset cycle.
  assign oWE      = {N_BANK{v_pipe[P_LAT-1] & ~iRESET}};
  assign oADDR_WR = a_pipe[P_LAT-1];

`ifdef FHT_REORDER_SCALE_EN
  localparam int HALF_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [D_BIT:0] HALF    = (SHIFT > 0) ? ((D_BIT+1)'(1) << HALF_SH) : '0;
  localparam logic signed [D_BIT:0] SAT_MAX = {2'b00, {(D_BIT-1){1'b1}}};
  localparam logic signed [D_BIT:0] SAT_MIN = {2'b11, {(D_BIT-1){1'b0}}};

  // One guard bit keeps the rounding add from overflowing.
  function automatic logic [D_BIT-1:0] scale_word(input logic [D_BIT-1:0] w);
    logic signed [D_BIT:0] sum;
    logic signed [D_BIT:0] shr;
    sum = $signed({w[D_BIT-1], w}) + HALF;
    shr = sum >>> SHIFT;
    if (shr > SAT_MAX)      shr = SAT_MAX;
    else if (shr < SAT_MIN) shr = SAT_MIN;
    return shr[D_BIT-1:0];
  endfunction

  logic [N_BANK*D_BIT-1:0] data_q;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      data_q <= '0;
    end else begin
      for (int b = 0; b < N_BANK; b++)
        data_q[b*D_BIT +: D_BIT] <= scale_word(iDATA_RD[b*D_BIT +: D_BIT]);
    end
  end

  assign oDATA_WR = data_q;
`else
  assign oDATA_WR = iDATA_RD;
`endif

endmodule

// File: tb/tb_fht_bitrev_reorder.sv
`timescale 1ns/1ps
module tb_fht_bitrev_reorder;
  localparam int AB   = 4;
  localparam int NB   = 4;
  localparam int DB   = 16;
  localparam int ROWS = 16;
`ifdef FHT_REORDER_SCALE_EN
  localparam int SC = 1;
  localparam int SH = 4;
`else
  localparam int SC = 0;
  localparam int SH = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst [2];
  logic              start [2];
  logic              mode [2];
  logic              clr [2];
  logic [AB-1:0]     addr_rd [2];
  logic [AB-1:0]     addr_wr [2];
  logic [NB*DB-1:0]  data_rd [2];
  logic [NB*DB-1:0]  data_wr [2];
  logic [NB-1:0]     we [2];
  logic              busy [2];
  logic              rdy [2];

  logic [DB-1:0]     src_mem [2][ROWS][NB];
  logic [DB-1:0]     dst [2][ROWS][NB];
  logic [AB-1:0]     rpipe [2][3];

  int   total = 0;
  int   bad = 0;
  logic chk_en = 1'b0;

  logic running [2];
  int   cyc [2];
  logic rmode [2];
  int   wr_cnt [2];
  int   rdy_cnt [2];
  int   first_wr [2];
  int   rdy_cyc [2];

  fht_bitrev_reorder #(.D_BIT(DB), .A_BIT(AB), .N_BANK(NB), .RD_LAT(1), .SHIFT(SH)) dut0 (
    .iCLK(clk), .iRESET(rst[0]), .iSTART(start[0]), .iMODE(mode[0]),
    .oADDR_RD(addr_rd[0]), .iDATA_RD(data_rd[0]), .oADDR_WR(addr_wr[0]),
    .oDATA_WR(data_wr[0]), .oWE(we[0]), .oBUSY(busy[0]), .oRDY(rdy[0]));

  fht_bitrev_reorder #(.D_BIT(DB), .A_BIT(AB), .N_BANK(NB), .RD_LAT(3), .SHIFT(SH)) dut1 (
    .iCLK(clk), .iRESET(rst[1]), .iSTART(start[1]), .iMODE(mode[1]),
    .oADDR_RD(addr_rd[1]), .iDATA_RD(data_rd[1]), .oADDR_WR(addr_wr[1]),
    .oDATA_WR(data_wr[1]), .oWE(we[1]), .oBUSY(busy[1]), .oRDY(rdy[1]));

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int rev4(int r);
    int res = 0;
    for (int j = 0; j < AB; j++)
      if (((r >> j) & 1) == 1) res += (1 << (AB - 1 - j));
    return res;
  endfunction

  function automatic logic [DB-1:0] model_word(logic [DB-1:0] v);
    int x;
    x = int'($signed(v));
`ifdef FHT_REORDER_SCALE_EN
    x = (x + (1 << (SH - 1))) >>> SH;
    if (x > 32767) x = 32767;
    if (x < -32768) x = -32768;
`endif
    return x[DB-1:0];
  endfunction

  function automatic logic [NB*DB-1:0] exp_row(int i, int r, logic m);
    logic [NB*DB-1:0] p;
    int s;
    s = m ? r : rev4(r);
    for (int b = 0; b < NB; b++) p[b*DB +: DB] = model_word(src_mem[i][s][b]);
    return p;
  endfunction

  function automatic logic [NB*DB-1:0] dst_row(int i, int r);
    logic [NB*DB-1:0] p;
    for (int b = 0; b < NB; b++) p[b*DB +: DB] = dst[i][r][b];
    return p;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(int i, logic m);
    start[i] = 1'b1;
    mode[i]  = m;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  // Source RAM: address registered lat_of(i) times, data read from the last stage.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rpipe[i][0] <= addr_rd[i];
      rpipe[i][1] <= rpipe[i][0];
      rpipe[i][2] <= rpipe[i][1];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      data_rd[i] = '0;
      for (int b = 0; b < NB; b++)
        data_rd[i][b*DB +: DB] = src_mem[i][rpipe[i][lat_of(i)-1]][b];
    end
  end

  // Destination RAM.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) begin
        for (int r = 0; r < ROWS; r++)
          for (int b = 0; b < NB; b++) dst[i][r][b] <= 16'hDEAD;
      end else begin
        for (int b = 0; b < NB; b++)
          if (we[i][b]) dst[i][addr_wr[i]][b] <= data_wr[i][b*DB +: DB];
      end
    end
  end

  // Run tracker: cyc = spec cycle number of the current clock period.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) running[i] <= 1'b0;
      else if (running[i]) begin
        cyc[i] <= cyc[i] + 1;
        if (cyc[i] >= ROWS + lat_of(i) + SC + 1) running[i] <= 1'b0;
      end else if (start[i]) begin
        running[i] <= 1'b1;
        cyc[i]     <= 1;
        rmode[i]   <= mode[i];
      end
    end
  end

  always @(negedge clk) begin : cmp
    int   wf;
    int   wl;
    int   en;
    logic we_x;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        wf   = 1 + lat_of(i) + SC;
        wl   = ROWS + lat_of(i) + SC;
        en   = wl + 1;
        we_x = running[i] && cyc[i] >= wf && cyc[i] <= wl && !rst[i];
        if (running[i] && cyc[i] == 1) begin
          wr_cnt[i]   = 0;
          rdy_cnt[i]  = 0;
          first_wr[i] = -1;
          rdy_cyc[i]  = -1;
        end
        if (we[i] != '0) begin
          wr_cnt[i]++;
          if (first_wr[i] < 0) first_wr[i] = cyc[i];
        end
        if (rdy[i]) begin
          rdy_cnt[i]++;
          rdy_cyc[i] = cyc[i];
        end
        chk($sformatf("we%0d c%0d", i, cyc[i]), we[i], we_x ? 4'hF : 4'h0);
        chk($sformatf("rdy%0d c%0d", i, cyc[i]), rdy[i], running[i] && cyc[i] == en);
        chk($sformatf("busy%0d c%0d", i, cyc[i]), busy[i], running[i] && cyc[i] >= 1 && cyc[i] < en);
        if (running[i] && cyc[i] <= ROWS)
          chk($sformatf("addr_rd%0d c%0d", i, cyc[i]), addr_rd[i],
              rmode[i] ? cyc[i] - 1 : rev4(cyc[i] - 1));
        if (we_x) begin
          chk($sformatf("addr_wr%0d c%0d", i, cyc[i]), addr_wr[i], cyc[i] - wf);
          chk($sformatf("data_wr%0d c%0d", i, cyc[i]), data_wr[i], exp_row(i, cyc[i] - wf, rmode[i]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; mode[i] = 1'b0; clr[i] = 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int b = 0; b < NB; b++) src_mem[i][r][b] = DB'(256 * b + r);
`ifdef FHT_REORDER_SCALE_EN
      src_mem[i][0][0] = 16'hFFE8;
      src_mem[i][0][1] = 16'h7FF8;
`endif
    end
    repeat (3) @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset addr_rd%0d", i), addr_rd[i], 0);
      chk($sformatf("reset addr_wr%0d", i), addr_wr[i], 0);
      chk($sformatf("reset we%0d", i), we[i], 0);
      chk($sformatf("reset busy%0d", i), busy[i], 0);
      chk($sformatf("reset rdy%0d", i), rdy[i], 0);
    end
    clr[0] = 1'b1; clr[1] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0; clr[1] = 1'b0;

    // Bit-reverse reorder.
    do_start(0, 1'b0);
    repeat (22) @(posedge clk); #1;
    chk("bitrev writes", wr_cnt[0], 16);
    chk("bitrev first write cycle", first_wr[0], 2 + SC);
    chk("bitrev rdy count", rdy_cnt[0], 1);
    chk("bitrev rdy cycle", rdy_cyc[0], 18 + SC);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("bitrev dst row %0d", r), dst_row(0, r), exp_row(0, r, 1'b0));
`ifdef FHT_REORDER_SCALE_EN
    chk("scale -24", dst[0][0][0], 16'hFFFF);
    chk("scale 0x7FF8", dst[0][0][1], 16'h0800);
`else
    chk("literal row 1", dst_row(0, 1), {16'd776, 16'd520, 16'd264, 16'd8});
    chk("literal row 3", dst_row(0, 3), {16'd780, 16'd524, 16'd268, 16'd12});
`endif

    // Linear copy; mode flipped mid-run must be ignored.
    clr[0] = 1'b1; @(posedge clk); #1; clr[0] = 1'b0;
    do_start(0, 1'b1);
    repeat (3) @(posedge clk); #1;
    mode[0] = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("linear writes", wr_cnt[0], 16);
    chk("linear rdy count", rdy_cnt[0], 1);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("linear dst row %0d", r), dst_row(0, r), exp_row(0, r, 1'b1));

    // Extra starts in cycles 5 and 18 are ignored.
    do_start(0, 1'b0);
    repeat (4) @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (12) @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("restart writes", wr_cnt[0], 16);
    chk("restart rdy count", rdy_cnt[0], 1);

    // Reset sampled in cycle 9 aborts the run.
    clr[0] = 1'b1; @(posedge clk); #1; clr[0] = 1'b0;
    do_start(0, 1'b0);
    repeat (8) @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    repeat (15) @(posedge clk); #1;
    chk("abort writes", wr_cnt[0], 7 - SC);
    chk("abort rdy count", rdy_cnt[0], 0);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("abort dst row %0d", r), dst_row(0, r),
          (r < 7 - SC) ? exp_row(0, r, 1'b0) : {4{16'hDEAD}});

    // Read latency 3.
    do_start(1, 1'b0);
    repeat (26) @(posedge clk); #1;
    chk("lat3 writes", wr_cnt[1], 16);
    chk("lat3 first write cycle", first_wr[1], 4 + SC);
    chk("lat3 rdy cycle", rdy_cyc[1], 20 + SC);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("lat3 dst row %0d", r), dst_row(1, r), exp_row(1, r, 1'b0));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fht_bitrev_reorder.md
# fht_bitrev_reorder

Hardware bit-reverse reorder engine between FHT result RAM and the next transform's input RAM. Reads all `N_BANK` banks of a source RAM in parallel, one row per clock, and writes each row to a destination RAM at the natural-order address. The source row is taken either at the bit-reversed address or at the same address. This replaces the slow per-bank, per-word rewrite between FHT and IFHT passes, and supports any bank count, depth and data width.

## Interface
Parameters:
- `D_BIT`, 16, data word width per bank
- `A_BIT`, 8, row address width; depth = 2^`A_BIT` rows per bank
- `N_BANK`, 4, number of parallel banks (≥1)
- `RD_LAT`, 1, source RAM read latency in clocks (1..3)
- `SHIFT`, 0, right-shift amount applied when scaling is compiled in (0..`D_BIT`-1)

Ports (one clock; reset is synchronous, active-high):
- `iCLK`  in  1  clock
- `iRESET`  in  1  synchronous active-high reset
- `iSTART`  in  1  start pulse; sampled only in IDLE
- `iMODE`  in  1  0 = bit-reverse reorder, 1 = linear copy
- `oADDR_RD`  out  `A_BIT`  source read address, shared by all banks
- `iDATA_RD`  in  `N_BANK*D_BIT`  source read data; bank b is in bits [b*D_BIT +: D_BIT]
- `oADDR_WR`  out  `A_BIT`  destination write address, shared by all banks
- `oDATA_WR`  out  `N_BANK*D_BIT`  destination write data, packed the same way as `iDATA_RD`
- `oWE`  out  `N_BANK`  per-bank write enable; all bits equal
- `oBUSY`  out  1  high from the cycle after an accepted start until the last write completes
- `oRDY`  out  1  one-cycle done pulse

## Operation
- States:
  - IDLE: `iSTART`=1 latches `iMODE`, clears `cnt`, and moves to READ.
  - READ: drives `oADDR_RD` = `mode ? cnt : bitrev(cnt)`; `cnt` increments each cycle; when `cnt` = 2^`A_BIT`-1, moves to DRAIN.
  - DRAIN: waits `RD_LAT` cycles for the pipeline to empty, then moves to DONE.
  - DONE: asserts `oRDY` for one cycle, then returns to IDLE.
- `bitrev` reverses all `A_BIT` bits: bit i maps to bit `A_BIT`-1-i.
- Write pipeline:
  - A valid flag and `cnt` are delayed `RD_LAT` stages.
  - `oWE` = all ones when the delayed valid flag is set.
  - `oADDR_WR` = delayed `cnt`.
  - `oDATA_WR` = `iDATA_RD` (combinational from the RAM output; no extra register).
- `iMODE` is latched at start; changing it mid-run has no effect.
- `iSTART` outside IDLE is ignored (no queueing, no restart).
- `iRESET` mid-run aborts the run immediately:
  - state returns to IDLE and the pipeline valid flags clear;
  - no further writes occur;
  - no `oRDY` is issued.
- Destination rows already written before an abort keep their data; the block does not clean them up.
- `cnt` wrap from 2^`A_BIT`-1 to 0 must not produce an extra read cycle.

## Timing
- Reset values:
  - `oADDR_RD`=0, `oADDR_WR`=0, `oDATA_WR` pipeline regs=0, `oWE`=0, `oBUSY`=0, `oRDY`=0
  - state IDLE, `cnt`=0
- Start accepted at cycle 0 (rising edge sampling `iSTART`=1).
- Reads and busy:
  - first read address is presented in cycle 1; `oBUSY`=1 from cycle 1;
  - last read address is presented in cycle 2^`A_BIT`.
- Writes:
  - first write (`oWE`≠0) occurs in cycle 1+`RD_LAT`;
  - last write occurs in cycle 2^`A_BIT`+`RD_LAT`.
- Completion:
  - `oRDY`=1 in cycle 2^`A_BIT`+`RD_LAT`+1;
  - `oBUSY` falls in that same cycle.
- The earliest next start is accepted in cycle 2^`A_BIT`+`RD_LAT`+2.
- Throughput: one row (`N_BANK` words) per clock, with no bubbles.

## Configuration
- `FHT_REORDER_SCALE_EN` defined:
  - each word is arithmetically right-shifted by `SHIFT`, rounding half up (add 2^(`SHIFT`-1) before the shift when `SHIFT`>0);
  - results saturate to the signed `D_BIT` range;
  - this adds one register stage, so write and `oRDY` latency each grow by 1 cycle.
- Not defined: data passes unmodified and latencies are exactly as stated above.

## Test plan
Defaults for all scenarios: `A_BIT`=4, `N_BANK`=4, `D_BIT`=16, `RD_LAT`=1, macro off.
- Bit-reverse: source bank b, row r = 256·b+r; start with `iMODE`=0.
  - dest row 1 = {8, 264, 520, 776}; row 3 = {12, 268, 524, 780}.
  - 16 writes in cycles 2..17; `oRDY` in cycle 18.
- Linear copy, `iMODE`=1: every dest row equals its source row; write addresses run 0..15 in order.
- `iSTART` asserted again in cycles 5 and 18: both ignored; exactly 16 writes occur and one `oRDY`.
- `iRESET` pulsed in cycle 9:
  - `oWE`=0 from cycle 10 onward, no `oRDY`;
  - dest rows 0..6 are written, rows 7..15 are unchanged.
- `RD_LAT`=3 with a RAM model of matching latency: data is still correct; first write in cycle 4, `oRDY` in cycle 20.
- Macro on, `SHIFT`=4: source word -24 → -1 (written as 0xFFFF); 0x7FF8 → 0x0800; `oRDY` in cycle 19.
